pll_phase_ctrl: RTL and testbench

PLL_PHASE_CTRL -- requirements
Module: pll_phase_ctrl

---
 rtl/pll_phase_ctrl.sv | 158 +++++++++++++++
 tb/tb_pll_phase_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pll_phase_ctrl.sv
// PLL dynamic phase-shift sequencer: drives PHASESEL/PHASEDIR and timed
// active-low PHASESTEP / PHASELOADREG strobes, then waits for PLL lock.
module pll_phase_ctrl #(
  parameter int SETUP_CYC  = 2,
  parameter int PULSE_CYC  = 4,
  parameter int GAP_CYC    = 4,
  parameter int SETTLE_CYC = 16,
  parameter int LOCK_TMO   = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_sel,
  input  logic       cmd_dir,
  input  logic       cmd_load,
  input  logic [7:0] cmd_steps,
  input  logic       pll_locked,
  output logic [1:0] phasesel,
  output logic       phasedir,
  output logic       phasestep,
  output logic       phaseloadreg,
  output logic       busy,
  output logic       done,
  output logic       lock_err
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, GAP, SETTLE, WAITLK, DONE} state_t;

  localparam int MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_GS = (GAP_CYC > SETTLE_CYC) ? GAP_CYC : SETTLE_CYC;
  localparam int MAX_A  = (MAX_SP > MAX_GS) ? MAX_SP : MAX_GS;
  localparam int MAXC   = (MAX_A > LOCK_TMO) ? MAX_A : LOCK_TMO;
  localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef logic [CW-1:0] cnt_t;

  // Timed states load duration-1 and leave when the counter reaches zero.
  localparam cnt_t SETUP_LD  = cnt_t'(SETUP_CYC - 1);
  localparam cnt_t PULSE_LD  = cnt_t'(PULSE_CYC - 1);
  localparam cnt_t GAP_LD    = cnt_t'(GAP_CYC - 1);
  localparam cnt_t SETTLE_LD = cnt_t'(SETTLE_CYC - 1);
  localparam cnt_t TMO_LD    = cnt_t'(LOCK_TMO - 1);

  state_t     state, state_nx;
  cnt_t       cnt, cnt_nx;
  logic [7:0] steps_q, steps_nx;
  logic       load_q;
  logic       err_nx;
  logic       lk_meta, lk;
  logic       accept;

  assign cmd_ready = (state == IDLE) && lk;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // pll_locked comes from the PLL's own clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta <= 1'b0;
      lk      <= 1'b0;
    end else begin
      // NOTE: non-blocking so both flops sample old values and form a real 2-stage chain.
      lk_meta <= pll_locked;
      lk      <= lk_meta;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nx = state;
    cnt_nx   = (cnt != '0) ? cnt - cnt_t'(1) : cnt;
    steps_nx = steps_q;
    err_nx   = lock_err;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (accept) begin
          err_nx   = 1'b0;
          steps_nx = cmd_steps;
          if (!cmd_load && cmd_steps == 8'd0) begin
            state_nx = DONE;
          end else begin
            state_nx = SETUP;
            cnt_nx   = SETUP_LD;
          end
        end
      end
      SETUP: if (cnt == '0) begin
        state_nx = STROBE;
        cnt_nx   = PULSE_LD;
      end
      STROBE: if (cnt == '0) begin
        steps_nx = (steps_q != 8'd0) ? steps_q - 8'd1 : 8'd0;
        if (load_q || steps_q <= 8'd1) begin
          state_nx = SETTLE;
          cnt_nx   = SETTLE_LD;
        end else begin
          state_nx = GAP;
          cnt_nx   = GAP_LD;
        end
      end
      GAP: if (cnt == '0) begin
        state_nx = STROBE;
        cnt_nx   = PULSE_LD;
      end
      SETTLE: if (cnt == '0) begin
        state_nx = WAITLK;
        cnt_nx   = TMO_LD;
      end
      WAITLK: begin
        if (lk) begin
          state_nx = DONE;
        end else if (cnt == '0) begin
          state_nx = DONE;
          err_nx   = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Strobes are registered from the next state so the PLL sees glitch-free edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      steps_q      <= 8'd0;
      load_q       <= 1'b0;
      lock_err     <= 1'b0;
      phasesel     <= 2'd0;
      phasedir     <= 1'b1;
      phasestep    <= 1'b1;
      phaseloadreg <= 1'b1;
    end else begin
      steps_q      <= steps_nx;
      lock_err     <= err_nx;
      if (accept) begin
        phasesel <= cmd_sel;
        phasedir <= cmd_dir;
        load_q   <= cmd_load;
      end
      phasestep    <= !(state_nx == STROBE && !load_q);
      phaseloadreg <= !(state_nx == STROBE && load_q);
    end
  end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Randomized bench for pll_phase_ctrl: each command's waveform is compared
// cycle by cycle against timing derived arithmetically from the command.
module tb_pll_phase_ctrl;

  localparam int SETUP  = 2;
  localparam int PULSE  = 4;
  localparam int GAP    = 4;
  localparam int SETTLE = 16;
  localparam int TMO    = 1024;

  // lock scenarios for a command
  localparam int LK_STEADY  = 0;
  localparam int LK_TIMEOUT = 1;
  localparam int LK_GLITCH  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_sel = 2'd0;
  logic       cmd_dir = 1'b0;
  logic       cmd_load = 1'b0;
  logic [7:0] cmd_steps = 8'd0;
  logic       pll_locked = 1'b1;
  logic [1:0] phasesel;
  logic       phasedir, phasestep, phaseloadreg, busy, done, lock_err;

  int total = 0;
  int bad = 0;
  logic exp_err = 1'b0;

  pll_phase_ctrl #(
    .SETUP_CYC(SETUP), .PULSE_CYC(PULSE), .GAP_CYC(GAP),
    .SETTLE_CYC(SETTLE), .LOCK_TMO(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_dir(cmd_dir), .cmd_load(cmd_load), .cmd_steps(cmd_steps),
    .pll_locked(pll_locked), .phasesel(phasesel), .phasedir(phasedir),
    .phasestep(phasestep), .phaseloadreg(phaseloadreg), .busy(busy),
    .done(done), .lock_err(lock_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 0, 1);
  endtask

  // k counts samples after the accepting edge (k=0: first negedge after it).
  task automatic run_cmd(input logic [1:0] sel, input logic dir, input logic load,
                         input logic [7:0] steps, input int mode_in, input logic hold);
    int   n, mode, strobe_end, done_k, mism, done_seen;
    logic zero, active, exp_ps, exp_plr;
    zero = !load && steps == 8'd0;
    mode = zero ? LK_STEADY : mode_in;
    n    = load ? 1 : int'(steps);
    strobe_end = SETUP + n * (PULSE + GAP) - GAP;
    done_k = zero ? 0 : strobe_end + SETTLE + ((mode == LK_TIMEOUT) ? TMO : 1);

    wait_ready();
    check("err_before", int'(lock_err), int'(exp_err));
    cmd_valid = 1'b1;
    cmd_sel   = sel;
    cmd_dir   = dir;
    cmd_load  = load;
    cmd_steps = steps;
    @(negedge clk);

    mism = 0;
    done_seen = -1;
    for (int k = 0; k <= done_k + 1; k++) begin
      if (k > 0) @(negedge clk);
      active  = !zero && k >= SETUP && k < strobe_end && ((k - SETUP) % (PULSE + GAP)) < PULSE;
      exp_ps  = !(active && !load);
      exp_plr = !(active && load);
      if (phasestep !== exp_ps) mism++;
      if (phaseloadreg !== exp_plr) mism++;
      if (phasesel !== sel) mism++;
      if (phasedir !== dir) mism++;
      if (busy !== (k <= done_k)) mism++;
      if (done === 1'b1 && done_seen < 0) done_seen = k;
      if (done !== (k == done_k)) mism++;
      if (k == 0) begin
        check("err_clear", int'(lock_err), 0);
        if (!hold) cmd_valid = 1'b0;
      end
      if (hold) begin
        cmd_sel   = 2'($urandom_range(0, 3));
        cmd_dir   = 1'($urandom_range(0, 1));
        cmd_steps = 8'($urandom_range(0, 255));
        if (k == done_k + 1) cmd_valid = 1'b0;
      end
      if (mode != LK_STEADY && k == SETUP) pll_locked = 1'b0;
      if (mode == LK_GLITCH && k == strobe_end + 1) pll_locked = 1'b1;
    end
    check("wave", mism, 0);
    check("done_at", done_seen, done_k);
    exp_err = (mode == LK_TIMEOUT);
    check("lock_err", int'(lock_err), int'(exp_err));
    if (mode == LK_TIMEOUT) begin
      check("ready_unlocked", int'(cmd_ready), 0);
      pll_locked = 1'b1;
    end
  endtask

  task automatic reset_mid_strobe();
    int dones;
    wait_ready();
    cmd_valid = 1'b1; cmd_sel = 2'd1; cmd_dir = 1'b0; cmd_load = 1'b0; cmd_steps = 8'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_strobe", int'(phasestep), 0);
    rst_n = 1'b0;
    #1;
    check("rst_phasestep", int'(phasestep), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_phasesel", int'(phasesel), 0);
    check("rst_phasedir", int'(phasedir), 1);
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("rst_no_done", dones, 0);
    exp_err = 1'b0;
  endtask

  initial begin
    int r, mode;
    logic ld;
    logic [7:0] st;
    pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_phasestep0", int'(phasestep), 1);
    check("rst_phaseloadreg0", int'(phaseloadreg), 1);
    check("rst_phasedir0", int'(phasedir), 1);
    check("rst_done0", int'(done), 0);
    check("rst_lock_err0", int'(lock_err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_sync_delay", int'(cmd_ready), 0);

    run_cmd(2'd2, 1'b0, 1'b0, 8'd3, LK_STEADY, 1'b0);
    run_cmd(2'd1, 1'b1, 1'b1, 8'd9, LK_STEADY, 1'b0);
    run_cmd(2'd3, 1'b1, 1'b0, 8'd0, LK_STEADY, 1'b0);
    run_cmd(2'd0, 1'b0, 1'b0, 8'd2, LK_TIMEOUT, 1'b0);
    run_cmd(2'd2, 1'b1, 1'b0, 8'd2, LK_GLITCH, 1'b1);
    run_cmd(2'd1, 1'b0, 1'b1, 8'd0, LK_TIMEOUT, 1'b0);
    run_cmd(2'd3, 1'b0, 1'b0, 8'd255, LK_STEADY, 1'b0);
    reset_mid_strobe();

    for (int i = 0; i < 24; i++) begin
      ld = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      r  = int'($urandom_range(0, 9));
      mode = (r == 0) ? LK_TIMEOUT : (r <= 3) ? LK_GLITCH : LK_STEADY;
      run_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ld, st, mode,
              1'($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
